// File: rtl/button_conditioner.sv
// Push-button input stage: 2-FF synchroniser, per-bit debounce, press pulses,
// and per-frame latching of levels and taps with left/right conflict resolution.
module button_conditioner #(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 742500,
    parameter int unsigned CNT_W           = 20
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_frame_press,
    output logic [NUM_BTN-1:0] btn_debounced
);

    localparam int unsigned      NUM_PAIR = NUM_BTN / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] r_s1;
    logic [NUM_BTN-1:0] r_s2;
    logic [NUM_BTN-1:0] r_deb;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] r_level;
    logic [NUM_BTN-1:0] r_frame_press;
    logic [CNT_W-1:0]   r_cnt [NUM_BTN];

    logic [NUM_BTN-1:0] w_accept;
    logic [NUM_BTN-1:0] w_resolved;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // A change is accepted once s2 has differed from deb for DEBOUNCE_CYCLES edges.
    always_comb begin
        w_accept = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            w_accept[i] = (r_s2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_deb   <= '0;
            r_press <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            r_press <= w_accept & r_s2;
        end
    end

    // Opposing directions of one player cancel each other in the latched level.
    always_comb begin
        w_resolved = r_deb;
        for (int unsigned p = 0; p < NUM_PAIR; p++) begin
            if (r_deb[2*p] && r_deb[2*p+1]) begin
                w_resolved[2*p]   = 1'b0;
                w_resolved[2*p+1] = 1'b0;
            end
        end
    end

    // A press seen on the fsync cycle belongs to the closing frame, so clear wins.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_pending     <= '0;
            r_level       <= '0;
            r_frame_press <= '0;
        end else if (fsync) begin
            r_frame_press <= r_pending | r_press;
            r_level       <= w_resolved;
            r_pending     <= '0;
        end else begin
            r_pending     <= r_pending | r_press;
        end
    end

    assign btn_level       = r_level;
    assign btn_press       = r_press;
    assign btn_frame_press = r_frame_press;
    assign btn_debounced   = r_deb;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner: a window-based behavioural model is
// compared against every output on every cycle, plus a few literal checkpoints.
module tb_button_conditioner;

    localparam int unsigned NB    = 4;
    localparam int unsigned DB    = 16;
    localparam int unsigned FRAME = 50;

    logic          pixel_clk = 1'b0;
    logic          rst       = 1'b1;
    logic          fsync     = 1'b0;
    logic [NB-1:0] btn_raw   = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_frame_press;
    logic [NB-1:0] btn_debounced;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (5)
    ) dut (
        .pixel_clk       (pixel_clk),
        .rst             (rst),
        .fsync           (fsync),
        .btn_raw         (btn_raw),
        .btn_level       (btn_level),
        .btn_press       (btn_press),
        .btn_frame_press (btn_frame_press),
        .btn_debounced   (btn_debounced)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: deb takes value v once the last DB sampled s2 values all equal v.
    logic [NB-1:0] s1m = '0, s2m = '0;
    logic [NB-1:0] deb_m = '0, press_m = '0, acc_m = '0, frame_m = '0, level_m = '0;
    logic [DB-1:0] hist [NB];
    logic          started = 1'b0;

    function automatic logic [NB-1:0] resolve(input logic [NB-1:0] d);
        logic [NB-1:0] r;
        r = d;
        for (int p = 0; p < NB / 2; p++) begin
            if (d[2*p] && d[2*p+1]) begin
                r[2*p]   = 1'b0;
                r[2*p+1] = 1'b0;
            end
        end
        return r;
    endfunction

    always @(posedge pixel_clk) begin
        logic [NB-1:0] nd;
        started = 1'b1;
        if (rst) begin
            s1m = '0; s2m = '0; deb_m = '0; press_m = '0;
            acc_m = '0; frame_m = '0; level_m = '0;
            for (int i = 0; i < NB; i++) hist[i] = '0;
        end else begin
            nd = deb_m;
            for (int i = 0; i < NB; i++) begin
                hist[i] = {hist[i][DB-2:0], s2m[i]};
                if (hist[i] == '1)      nd[i] = 1'b1;
                else if (hist[i] == '0) nd[i] = 1'b0;
            end
            if (fsync) begin
                frame_m = acc_m | press_m;
                level_m = resolve(deb_m);
                acc_m   = '0;
            end else begin
                acc_m = acc_m | press_m;
            end
            press_m = nd & ~deb_m;
            deb_m   = nd;
            s2m     = s1m;
            s1m     = btn_raw;
        end
    end

    always @(negedge pixel_clk) begin
        if (started) begin
            chk("debounced",   btn_debounced,   deb_m);
            chk("press",       btn_press,       press_m);
            chk("frame_press", btn_frame_press, frame_m);
            chk("level",       btn_level,       level_m);
        end
    end

    int unsigned fcnt    = 0;
    logic        rand_fs = 1'b0;

    task automatic tick();
        fsync = (fcnt == FRAME - 1) || (rand_fs && ($urandom_range(0, 24) == 0));
        fcnt  = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
        @(posedge pixel_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NB; i++) hist[i] = '0;

        // Held button through reset, accepted 17 edges after s1 capture
        rst = 1'b1; btn_raw = 4'b0001;
        repeat (4) tick();
        chk("lit_reset_deb",   btn_debounced,   4'b0000);
        chk("lit_reset_press", btn_press,       4'b0000);
        rst = 1'b0;
        repeat (17) tick();
        chk("lit_edge16_deb", btn_debounced, 4'b0000);
        tick();
        chk("lit_edge17_deb",   btn_debounced, 4'b0001);
        chk("lit_edge17_press", btn_press,     4'b0001);
        tick();
        chk("lit_edge18_press", btn_press,     4'b0000);

        // Glitches on bit 1
        btn_raw = 4'b0011; repeat (10) tick();
        btn_raw = 4'b0001; repeat (5) tick();
        btn_raw = 4'b0011; repeat (15) tick();
        btn_raw = 4'b0001; tick();
        btn_raw = 4'b0011; repeat (15) tick();
        btn_raw = 4'b0001; repeat (20) tick();
        chk("lit_glitch_deb", btn_debounced, 4'b0001);

        // Short press of bit 2 inside a frame
        btn_raw = 4'b0101; repeat (40) tick();
        btn_raw = 4'b0001; repeat (2 * FRAME) tick();

        // Opposing directions held together
        btn_raw = 4'b0011; repeat (2 * FRAME) tick();
        chk("lit_conflict_level", btn_level,     4'b0000);
        chk("lit_conflict_deb",   btn_debounced, 4'b0011);
        btn_raw = 4'b0001; repeat (2 * FRAME) tick();
        chk("lit_release_level", btn_level, 4'b0001);

        // One-cycle reset mid-hold
        rst = 1'b1; tick();
        chk("lit_midrst_deb",   btn_debounced, 4'b0000);
        chk("lit_midrst_level", btn_level,     4'b0000);
        rst = 1'b0;
        repeat (17) tick();
        chk("lit_midrst_e16", btn_press, 4'b0000);
        tick();
        chk("lit_midrst_e17", btn_press, 4'b0001);
        repeat (2 * FRAME) tick();

        // Randomised segments with extra fsync strobes and rare resets
        rand_fs = 1'b1;
        for (int s = 0; s < 150; s++) begin
            btn_raw = 4'($urandom);
            for (int c = 0; c < int'($urandom_range(1, 40)); c++) begin
                rst = ($urandom_range(0, 399) == 0);
                tick();
            end
        end
        rst = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
